load_unit: RTL
==============

# load_unit

Multi-cycle load unit sitting directly downstream of the immediate generator in the load datapath. It takes the sign-extended 32-bit I-type immediate plus the rs1 base value, forms the effective address, performs one word read over a request/acknowledge memory port, then extracts and sign- or zero-extends the addressed byte, halfword or word for register writeback. While a load is in flight it holds `busy` high so the core stalls.

## Interface

Parameters:
- ADDR_W, 32, address and base/immediate width
- DATA_W, 32, memory data width; fixed at 32, byte lanes assume 4

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse: begin a load; sampled only in IDLE
- base  in  32  rs1 value
- immediate  in  32  sign-extended offset from immediate generator
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- busy  out  1  high in every state except IDLE
- mem_req  out  1  read request, held until accepted
- mem_addr  out  32  word-aligned address, {ea[31:2],2'b00}
- mem_ack  in  1  request accepted when mem_req && mem_ack at a clock edge
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data, little-endian lanes
- done  out  1  single-cycle pulse: load finished
- rd_data  out  32  extended result; valid with done, held until next done
- err  out  1  with done: misaligned or illegal funct3

## Operation

- ea = base + immediate, modulo 2^32 (carry out discarded); registered with funct3 on accepted start.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start=1 → decode check; if legal and aligned → REQ; else → DONE with err=1.
- Misaligned: LH/LHU with ea[0]=1; LW with ea[1:0]≠00. Illegal funct3 treated the same. No memory request issued; rd_data=0.
- REQ: mem_req=1, mem_addr stable; on mem_ack → WAIT; otherwise stay.
- WAIT: on mem_rvalid → capture extended data into rd_data, → DONE.
- DONE: done=1 for one cycle, err as determined, → IDLE.
- Extraction: LB/LBU take mem_rdata[8*ea[1:0]+7 : 8*ea[1:0]]; LH/LHU take mem_rdata[16*ea[1]+15 : 16*ea[1]]; LW takes all 32 bits. LB/LH replicate the top selected bit, LBU/LHU zero-fill.
- start outside IDLE is ignored, not queued.
- mem_rvalid in IDLE, REQ or DONE is ignored.

## Timing

- Reset values: state IDLE, busy=0, mem_req=0, mem_addr=0, done=0, rd_data=0, err=0. Reset is asynchronous, so outputs clear immediately on rst assertion.
- Reset mid-operation aborts the load. There is no done pulse, and any late mem_rvalid is ignored.
- Start at edge 0 → busy and mem_req high from cycle 1.
- Ack at edge 1 → WAIT from cycle 2.
- Earliest rvalid is at edge 2, so done is high in cycle 3.
- Minimum latency is 3 cycles from start to done. Each ack-wait or rvalid-wait cycle adds 1.
- Error path: start at edge 0 → done=1, err=1 in cycle 1.
- mem_rvalid coincident with mem_ack in REQ is ignored. The memory must return data no earlier than the cycle after acceptance.
- err is 0 on every non-error done and whenever done=0.
- rd_data changes only on the edge entering DONE.

## Structure

- Package `lsu_pkg` holds:
  - the funct3 load-type enum (LB, LH, LW, LBU, LHU)
  - the state enum (IDLE, REQ, WAIT, DONE)
  - the DATA_W constant
- The package is shared with the future store unit and the decoder.
- Sub-module `load_align` is combinational: (mem_rdata, ea[1:0], funct3) → 32-bit extended result. It is instantiated once in load_unit and is reusable by the store path.

## Test plan

- LW, base=0x1000, imm=0x0000_0004, mem_ack immediate, mem_rdata=0xDEAD_BEEF one cycle later:
  - mem_addr=0x1004
  - done in cycle 3, rd_data=0xDEAD_BEEF, err=0
- LB and LBU at ea=0x1003, mem_rdata=0x80FF_0000:
  - LB → rd_data=0xFFFF_FF80
  - LBU → rd_data=0x0000_0080
- LH at ea=0x2002, mem_rdata=0x8001_1234:
  - rd_data=0xFFFF_8001
  - LHU gives 0x0000_8001
- LW with base=0x0000_0000, imm=0xFFFF_FFFE (ea=0xFFFF_FFFE, wraps):
  - no mem_req
  - done=1, err=1 in cycle 1, rd_data=0
- Same for funct3=011.
- Back-pressure: hold mem_ack=0 for 5 cycles:
  - mem_req and mem_addr stable throughout
  - a second start during busy is ignored
  - exactly one done follows
- Assert rst in WAIT, then pulse mem_rvalid after release:
  - all outputs 0 immediately on rst
  - no done
  - a next start completes normally

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_pkg : load/store shared types (funct3 load kinds, FSM states, widths)
// Revision: 1.0
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam int LSU_DATA_W = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // True when funct3 names a load and the byte offset suits its size.
  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] ea_lo);
    case (f3)
      LB, LBU: load_ok = 1'b1;
      LH, LHU: load_ok = ~ea_lo[0];
      LW:      load_ok = (ea_lo == 2'b00);
      default: load_ok = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_align : selects byte/halfword/word lane and sign- or zero-extends it
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (ea_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  assign half_sel = ea_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    result_o = '0;
    case (funct3_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result_o = {24'b0, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LHU:     result_o = {16'b0, half_sel};
      LW:      result_o = rdata_i;
      default: result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_unit : multi-cycle load, one word read over req/ack port, lane extract
// Revision: 1.0
// ---------------------------------------------------------------------------
module load_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] immediate,
  input  logic [2:0]        funct3,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              err
);

  lsu_state_e        state_q;
  logic [2:0]        funct3_q;
  logic [1:0]        ea_lo_q;
  logic              busy_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              err_q;

  logic [ADDR_W-1:0] ea_d;
  logic [31:0]       aligned_d;

  assign ea_d = base + immediate;

  load_align u_align (
    .rdata_i  (mem_rdata),
    .ea_lo_i  (ea_lo_q),
    .funct3_i (funct3_q),
    .result_o (aligned_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'b000;
      ea_lo_q    <= 2'b00;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            ea_lo_q  <= ea_d[1:0];
            busy_q   <= 1'b1;
            if (load_ok(funct3, ea_d[1:0])) begin
              state_q    <= REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {ea_d[ADDR_W-1:2], 2'b00};
            end else begin
              // Rejected loads skip the bus entirely and report at once.
              state_q   <= DONE;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              rd_data_q <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            rd_data_q <= aligned_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

endmodule
`default_nettype wire
